// File: rtl/fxp_div_seq_if.sv
// fxp_div_seq_if: start/busy/done handshake bundle for the sequential
// fixed-point divider.
//   start, dd, ds             : requester -> divider
//   busy, done, q, dz, ovf    : divider -> requester
// Modports: master (requester side), slave (divider side).
interface fxp_div_seq_if #(
    parameter int DATA_W = 32
);
    logic              start;
    logic [DATA_W-1:0] dd;
    logic [DATA_W-1:0] ds;
    logic              busy;
    logic              done;
    logic [DATA_W-1:0] q;
    logic              dz;
    logic              ovf;

    modport master (output start, dd, ds, input busy, done, q, dz, ovf);
    modport slave  (input start, dd, ds, output busy, done, q, dz, ovf);
endinterface

// File: rtl/fxp_div_seq.sv
// fxp_div_seq: sequential signed fixed-point divider, q = dd / ds in
// Q(INT_BITS).(FRAC_BITS). Restoring long division on magnitudes, one
// quotient bit per clock, sign applied at the end; truncates toward zero.
// Ports:
//   clk  : clock, rising edge
//   rst  : asynchronous active-high reset
//   bus  : fxp_div_seq_if.slave (start/dd/ds in, busy/done/q/dz/ovf out)
// Latency: 57 cycles from start to done (1 cycle for a zero divisor).
// Build option: define FXP_DIV_SAT_EN to saturate q on overflow and on
// divide-by-zero; otherwise q wraps on overflow and is 0 on divide-by-zero.
module fxp_div_seq #(
    parameter int DATA_W    = 32,
    parameter int INT_BITS  = 8,
    parameter int FRAC_BITS = 24
) (
    input  logic           clk,
    input  logic           rst,
    fxp_div_seq_if.slave   bus
);
    localparam int QB = DATA_W + FRAC_BITS;
    localparam int CW = $clog2(QB);

    // Largest positive / negative magnitudes representable in DATA_W bits.
    localparam logic [QB-1:0]     MAXP = {{(QB-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic [QB-1:0]     MAXN = MAXP + 1'b1;
    localparam logic [DATA_W-1:0] QPOS = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic [DATA_W-1:0] QNEG = {1'b1, {(DATA_W-1){1'b0}}};

    generate
        if (INT_BITS + FRAC_BITS != DATA_W) begin : g_bad_fmt
            $error("fxp_div_seq: INT_BITS + FRAC_BITS must equal DATA_W");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, CALC, FIN} state_t;

    state_t            state, state_nx;
    logic [CW-1:0]     cnt;
    logic              sign;
    logic              zdiv;
    logic [DATA_W-1:0] nb;
    logic [QB-1:0]     nsh;
    logic [DATA_W:0]   rem;
    logic [QB-1:0]     qm;
    logic [DATA_W-1:0] q_r;
    logic              dz_r, ovf_r, done_r;
`ifdef FXP_DIV_SAT_EN
    logic              ddneg;
`endif

    // Magnitudes; the most negative value maps to 2^(DATA_W-1) unsigned.
    logic [DATA_W-1:0] na_c, nb_c;
    assign na_c = bus.dd[DATA_W-1] ? -bus.dd : bus.dd;
    assign nb_c = bus.ds[DATA_W-1] ? -bus.ds : bus.ds;

    // Trial subtraction one bit wider than R so the borrow is visible.
    logic [DATA_W+1:0] shifted, trial;
    logic              qbit;
    assign shifted = {rem, nsh[QB-1]};
    assign trial   = shifted - {2'b00, nb};
    assign qbit    = ~trial[DATA_W+1];

    // ---------------- FSM ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (bus.start) state_nx = (bus.ds == '0) ? FIN : CALC;
            CALC: if (cnt == '0) state_nx = FIN;
            FIN:  state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // ---------------- result formatting ----------------
    logic [DATA_W-1:0] q_nx;
    logic              ovf_nx;
    always_comb begin
        q_nx   = sign ? -qm[DATA_W-1:0] : qm[DATA_W-1:0];
        ovf_nx = sign ? (qm > MAXN) : (qm > MAXP);
`ifdef FXP_DIV_SAT_EN
        if (zdiv)        q_nx = ddneg ? QNEG : QPOS;
        else if (ovf_nx) q_nx = sign ? QNEG : QPOS;
`else
        if (zdiv)        q_nx = '0;
`endif
        if (zdiv) ovf_nx = 1'b0;
    end

    // ---------------- datapath ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt    <= '0;
            sign   <= 1'b0;
            zdiv   <= 1'b0;
            nb     <= '0;
            nsh    <= '0;
            rem    <= '0;
            qm     <= '0;
            q_r    <= '0;
            dz_r   <= 1'b0;
            ovf_r  <= 1'b0;
            done_r <= 1'b0;
`ifdef FXP_DIV_SAT_EN
            ddneg  <= 1'b0;
`endif
        end else begin
            done_r <= 1'b0;
            case (state)
                IDLE: if (bus.start) begin
                    sign <= bus.dd[DATA_W-1] ^ bus.ds[DATA_W-1];
                    zdiv <= (bus.ds == '0);
                    nb   <= nb_c;
                    nsh  <= {na_c, {FRAC_BITS{1'b0}}};
                    rem  <= '0;
                    qm   <= '0;
                    cnt  <= CW'(QB-1);
`ifdef FXP_DIV_SAT_EN
                    ddneg <= bus.dd[DATA_W-1];
`endif
                end
                CALC: begin
                    rem <= qbit ? trial[DATA_W:0] : shifted[DATA_W:0];
                    nsh <= {nsh[QB-2:0], 1'b0};
                    qm  <= {qm[QB-2:0], qbit};
                    cnt <= cnt - 1'b1;
                end
                FIN: begin
                    q_r    <= q_nx;
                    dz_r   <= zdiv;
                    ovf_r  <= ovf_nx;
                    done_r <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.busy = (state != IDLE);
    assign bus.done = done_r;
    assign bus.q    = q_r;
    assign bus.dz   = dz_r;
    assign bus.ovf  = ovf_r;
endmodule

// File: tb/tb_fxp_div_seq.sv
module tb_fxp_div_seq;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fxp_div_seq_if #(.DATA_W(32)) bus();

    fxp_div_seq #(.DATA_W(32), .INT_BITS(8), .FRAC_BITS(24)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    typedef struct {
        logic [31:0] dd;
        logic [31:0] ds;
        logic [31:0] qn;   // expected q, wrapping build
        logic [31:0] qs;   // expected q, saturating build
        bit          dz;
        bit          ovf;
        int          lat;
    } vec_t;

    typedef struct {
        logic [31:0] q;
        bit          dz;
        bit          ovf;
    } exp_t;

    exp_t sbq[$];
    int   nvec = 0;
    int   nerr = 0;
    bit   sat;
    vec_t tbl[12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Reference: 64-bit signed division of the pre-scaled dividend.
    task automatic model(input logic [31:0] a, input logic [31:0] b, output exp_t e);
        longint num, quo;
        e.dz = (b == 0);
        e.ovf = 0;
        e.q = 0;
        if (e.dz) begin
            if (sat) e.q = a[31] ? 32'h80000000 : 32'h7FFFFFFF;
        end else begin
            num = longint'($signed(a)) * 64'sd16777216;
            quo = num / longint'($signed(b));
            e.ovf = (quo > 64'sd2147483647) || (quo < -64'sd2147483648);
            e.q = quo[31:0];
            if (sat && e.ovf) e.q = (quo > 0) ? 32'h7FFFFFFF : 32'h80000000;
        end
    endtask

    // Scoreboard: every done pops one expectation.
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.busy && bus.done) begin
                nerr++;
                $display("FAIL busy_done_overlap: busy=1 done=1, expected never both");
            end
            if (bus.done) begin
                if (sbq.size() == 0) begin
                    nvec++;
                    nerr++;
                    $display("FAIL unexpected_done: done=1 q=0x%08h, expected no done", bus.q);
                end else begin
                    exp_t e;
                    e = sbq.pop_front();
                    chk("q",   bus.q,          e.q);
                    chk("dz",  32'(bus.dz),    32'(e.dz));
                    chk("ovf", 32'(bus.ovf),   32'(e.ovf));
                end
            end
        end
    end

    // Drive one start pulse accepted at the next rising edge (E0).
    task automatic start_div(input logic [31:0] a, input logic [31:0] b, input bit push,
                             input bit use_tbl, input exp_t te);
        exp_t e;
        @(negedge clk);
        bus.dd = a; bus.ds = b; bus.start = 1'b1;
        if (push) begin
            if (use_tbl) e = te; else model(a, b, e);
            sbq.push_back(e);
        end
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.dd = $urandom;   // must not be sampled after the start edge
        bus.ds = $urandom;
    endtask

    // Count edges until done shows; busy samples counted along the way.
    task automatic wait_done(input int maxc, output int n, output int bcnt);
        n = 0;
        bcnt = bus.busy ? 1 : 0;
        forever begin
            @(posedge clk);
            #1;
            n++;
            if (bus.done) break;
            if (bus.busy) bcnt++;
            if (n >= maxc) begin
                nvec++;
                nerr++;
                $display("FAIL done_timeout: no done after %0d cycles, expected done", n);
                break;
            end
        end
    endtask

    initial begin
        exp_t e, none;
        int n, b;
`ifdef FXP_DIV_SAT_EN
        sat = 1;
`else
        sat = 0;
`endif
        none = '{q: 0, dz: 0, ovf: 0};
        //        dd            ds            q wrap        q sat         dz ovf lat
        tbl[0]  = '{32'h06000000, 32'h02000000, 32'h03000000, 32'h03000000, 0, 0, 57};
        tbl[1]  = '{32'hFF000000, 32'h03000000, 32'hFFAAAAAB, 32'hFFAAAAAB, 0, 0, 57};
        tbl[2]  = '{32'h01000000, 32'h00000000, 32'h00000000, 32'h7FFFFFFF, 1, 0, 1};
        tbl[3]  = '{32'h64000000, 32'h00800000, 32'hC8000000, 32'h7FFFFFFF, 0, 1, 57};
        tbl[4]  = '{32'h80000000, 32'hFF000000, 32'h80000000, 32'h7FFFFFFF, 0, 1, 57};
        tbl[5]  = '{32'h80000000, 32'h01000000, 32'h80000000, 32'h80000000, 0, 0, 57};
        tbl[6]  = '{32'hFF000000, 32'h00000000, 32'h00000000, 32'h80000000, 1, 0, 1};
        tbl[7]  = '{32'h01800000, 32'hFF800000, 32'hFD000000, 32'hFD000000, 0, 0, 57};
        tbl[8]  = '{32'h00000001, 32'hFFFFFFFF, 32'hFF000000, 32'hFF000000, 0, 0, 57};
        tbl[9]  = '{32'h00000000, 32'h05000000, 32'h00000000, 32'h00000000, 0, 0, 57};
        tbl[10] = '{32'h7FFFFFFF, 32'h7FFFFFFF, 32'h01000000, 32'h01000000, 0, 0, 57};
        tbl[11] = '{32'h80000000, 32'h00800000, 32'h00000000, 32'h80000000, 0, 1, 57};

        rst = 1'b1;
        bus.start = 1'b0; bus.dd = '0; bus.ds = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", 32'(bus.busy), 0);
        chk("rst_done", 32'(bus.done), 0);
        chk("rst_q",    bus.q,         0);
        chk("rst_dz",   32'(bus.dz),   0);
        chk("rst_ovf",  32'(bus.ovf),  0);
        @(negedge clk);
        rst = 1'b0;

        // Directed table
        for (int i = 0; i < 12; i++) begin
            e.q = sat ? tbl[i].qs : tbl[i].qn;
            e.dz = tbl[i].dz;
            e.ovf = tbl[i].ovf;
            start_div(tbl[i].dd, tbl[i].ds, 1, 1, e);
            wait_done(200, n, b);
            chk($sformatf("latency[%0d]", i), 32'(n), 32'(tbl[i].lat));
            chk($sformatf("busy_cycles[%0d]", i), 32'(b), 32'(tbl[i].lat));
        end

        // Random operands against the reference model
        for (int i = 0; i < 8; i++) begin
            logic [31:0] a, d;
            a = $urandom;
            d = (i < 4) ? $urandom : ($urandom & 32'h00FFFFFF);
            if (d == 0) d = 32'h1;
            start_div(a, d, 1, 0, none);
            wait_done(200, n, b);
            chk("rand_latency", 32'(n), 57);
        end

        // Second start at E10 is ignored (a zero divisor would finish fast)
        start_div(32'h06000000, 32'h02000000, 1, 0, none);
        repeat (9) @(posedge clk);
        @(negedge clk);
        bus.dd = 32'h01000000; bus.ds = 32'h0; bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        wait_done(200, n, b);
        chk("ignored_start_latency", 32'(n), 47);

        // Back-to-back: start held in the done cycle launches the next divide
        start_div(32'hFF000000, 32'h03000000, 1, 0, none);
        wait_done(200, n, b);
        bus.dd = 32'h01800000; bus.ds = 32'hFF800000; bus.start = 1'b1;
        model(bus.dd, bus.ds, e);
        sbq.push_back(e);
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        chk("b2b_busy", 32'(bus.busy), 1);
        wait_done(200, n, b);
        chk("b2b_latency", 32'(n), 57);

        // Reset at E20 aborts with no done
        start_div(32'h06000000, 32'h02000000, 0, 0, none);
        repeat (19) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("abort_busy", 32'(bus.busy), 0);
        chk("abort_q",    bus.q,         0);
        chk("abort_done", 32'(bus.done), 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (80) @(posedge clk);
        #1;
        chk("abort_idle_busy", 32'(bus.busy), 0);
        chk("pending_results", 32'(sbq.size()), 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
